// File: rtl/issue_lane_credit_tracker_pkg.sv
// rtl/issue_lane_credit_tracker_pkg.sv - shared types and constants for the issue lane credit tracker
package issue_lane_credit_tracker_pkg;
  localparam int DISPATCH_WIDTH  = 4;
  localparam int ISSUE_WIDTH     = 6;
  localparam int ISSUE_WIDTH_LOG = 3;
  localparam int LANE_CAP        = 8;
  localparam int CNT_W           = 4;
  localparam int REQ_W           = $clog2(DISPATCH_WIDTH + 1);

  typedef logic [ISSUE_WIDTH_LOG-1:0] lane_idx_t;
  typedef logic [CNT_W-1:0]           count_t;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/issue_lane_credit_tracker_lane_req_counter.sv
// rtl/issue_lane_credit_tracker_lane_req_counter.sv - popcount of dispatch slots targeting one lane
module lane_req_counter
  import issue_lane_credit_tracker_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic                                      i_en,
  input  logic [DISPATCH_WIDTH-1:0]                 i_valid,
  input  logic [DISPATCH_WIDTH*ISSUE_WIDTH_LOG-1:0] i_pipes,
  output logic [REQ_W-1:0]                          o_req
);
  always_comb begin
    o_req = '0;
    if (i_en) begin
      for (int s = 0; s < DISPATCH_WIDTH; s++) begin
        if (i_valid[s] && (i_pipes[s*ISSUE_WIDTH_LOG +: ISSUE_WIDTH_LOG] == lane_idx_t'(LANE)))
          o_req = o_req + 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_lane_credit_tracker.sv
// rtl/issue_lane_credit_tracker.sv - per-lane issue queue occupancy, full flags and dispatch stall
module issue_lane_credit_tracker
  import issue_lane_credit_tracker_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      recoverFlag_i,
  input  logic                                      backEndReady_i,
  input  logic [DISPATCH_WIDTH-1:0]                 dispValid_i,
  input  logic [DISPATCH_WIDTH*ISSUE_WIDTH_LOG-1:0] exePipes_i,
  input  logic [ISSUE_WIDTH-1:0]                    laneActive_i,
  input  logic [ISSUE_WIDTH-1:0]                    issueGrant_i,
  output logic                                      stall_o,
  output logic [ISSUE_WIDTH-1:0]                    laneFull_o,
  output logic [ISSUE_WIDTH*CNT_W-1:0]              laneCount_o,
  output logic                                      error_o
);
  state_t                             r_state, w_state_next;
  logic [ISSUE_WIDTH-1:0][CNT_W-1:0]  r_count;
  logic [ISSUE_WIDTH-1:0][CNT_W-1:0]  w_count_next;
  logic [ISSUE_WIDTH-1:0][REQ_W-1:0]  w_req;
  logic [ISSUE_WIDTH-1:0]             w_grant_empty;
  logic                               w_over, w_bad, w_accept, r_error;

  for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
    lane_req_counter #(.LANE(l)) u_req (
      .i_en   (backEndReady_i),
      .i_valid(dispValid_i),
      .i_pipes(exePipes_i),
      .o_req  (w_req[l])
    );
  end

  // Same-cycle grants are deliberately not credited when checking for overflow.
  always_comb begin
    w_over = 1'b0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      if (({1'b0, r_count[l]} + (CNT_W+1)'(w_req[l])) > (CNT_W+1)'(LANE_CAP))
        w_over = 1'b1;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      if (backEndReady_i && dispValid_i[s]) begin
        if (exePipes_i[s*ISSUE_WIDTH_LOG +: ISSUE_WIDTH_LOG] >= lane_idx_t'(ISSUE_WIDTH))
          w_bad = 1'b1;
        else if (!laneActive_i[exePipes_i[s*ISSUE_WIDTH_LOG +: ISSUE_WIDTH_LOG]])
          w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    stall_o      = 1'b0;
    case (r_state)
      RUN: begin
        stall_o = backEndReady_i & (w_over | w_bad | recoverFlag_i);
        if (recoverFlag_i) w_state_next = FLUSH;
      end
      FLUSH: begin
        stall_o      = 1'b1;
        w_state_next = recoverFlag_i ? FLUSH : RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  assign w_accept = backEndReady_i & ~stall_o & (r_state == RUN);

  always_comb begin
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      logic [CNT_W:0] w_sum;
      w_grant_empty[l] = issueGrant_i[l] & (r_count[l] == '0);
      w_sum = {1'b0, r_count[l]}
            + (w_accept ? (CNT_W+1)'(w_req[l]) : '0)
            - (CNT_W+1)'(issueGrant_i[l] & (r_count[l] != '0));
      w_count_next[l] = w_sum[CNT_W-1:0];
    end
  end

  // Recovery wins over any same-cycle dispatch or issue; FLUSH holds the cleared counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (r_state == RUN) begin
      if (recoverFlag_i) r_count <= '0;
      else               r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_error <= 1'b0;
    else if (w_bad || ((r_state == RUN) && (|w_grant_empty)))
      r_error <= 1'b1;
  end

  always_comb begin
    for (int l = 0; l < ISSUE_WIDTH; l++)
      laneFull_o[l] = (r_count[l] == count_t'(LANE_CAP));
  end

  assign laneCount_o = r_count;
  assign error_o     = r_error;
endmodule

// File: tb/tb_issue_lane_credit_tracker.sv
// tb/tb_issue_lane_credit_tracker.sv - directed self-checking bench for issue_lane_credit_tracker
module tb_issue_lane_credit_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic        recoverFlag_i;
  logic        backEndReady_i;
  logic [3:0]  dispValid_i;
  logic [11:0] exePipes_i;
  logic [5:0]  laneActive_i;
  logic [5:0]  issueGrant_i;
  logic        stall_o;
  logic [5:0]  laneFull_o;
  logic [23:0] laneCount_o;
  logic        error_o;

  int n_assert = 0;
  int n_fail   = 0;

  issue_lane_credit_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (recoverFlag_i),
    .backEndReady_i(backEndReady_i),
    .dispValid_i   (dispValid_i),
    .exePipes_i    (exePipes_i),
    .laneActive_i  (laneActive_i),
    .issueGrant_i  (issueGrant_i),
    .stall_o       (stall_o),
    .laneFull_o    (laneFull_o),
    .laneCount_o   (laneCount_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int l);
    return {28'd0, laneCount_o[l*4 +: 4]};
  endfunction

  task automatic drive(input logic ber, input logic [3:0] v, input logic [11:0] p,
                       input logic [5:0] g, input logic rec);
    backEndReady_i = ber;
    dispValid_i    = v;
    exePipes_i     = p;
    issueGrant_i   = g;
    recoverFlag_i  = rec;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, 4'h0, 12'h0, 6'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    laneActive_i = 6'h3F;
    drive(1'b0, 4'h0, 12'h0, 6'h0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_count", {8'd0, laneCount_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_full", {26'd0, laneFull_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // slots {2,3,2,0}
    drive(1'b1, 4'hF, {3'd0, 3'd2, 3'd3, 3'd2}, 6'h0, 1'b0);
    check("disp4_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("disp4_l0", cnt(0), 32'd1);
    check("disp4_l1", cnt(1), 32'd0);
    check("disp4_l2", cnt(2), 32'd2);
    check("disp4_l3", cnt(3), 32'd1);
    check("disp4_l5", cnt(5), 32'd0);

    drive(1'b1, 4'hF, {3'd2, 3'd2, 3'd2, 3'd2}, 6'h0, 1'b0);
    tick();
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd2}, 6'h0, 1'b0);
    tick();
    check("fill_l2_7", cnt(2), 32'd7);
    check("fill_full_clear", {26'd0, laneFull_o}, 32'd0);

    drive(1'b1, 4'h3, {3'd0, 3'd0, 3'd2, 3'd2}, 6'h0, 1'b0);
    check("over_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("over_l2_held", cnt(2), 32'd7);

    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd2}, 6'h0, 1'b0);
    check("retry_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("retry_l2_8", cnt(2), 32'd8);
    check("retry_full", {26'd0, laneFull_o}, 32'h04);

    // grant and dispatch on a full lane: no credit, only the grant lands
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd2}, 6'h04, 1'b0);
    check("nocredit_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("nocredit_l2_7", cnt(2), 32'd7);
    check("nocredit_full", {26'd0, laneFull_o}, 32'd0);

    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd3}, 6'h08, 1'b0);
    check("net_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("net_l3_1", cnt(3), 32'd1);
    check("net_error", {31'd0, error_o}, 32'd0);

    // recovery with a bundle present
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd0}, 6'h0, 1'b1);
    check("rec_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("rec_cleared", {8'd0, laneCount_o}, 32'd0);
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd0}, 6'h0, 1'b0);
    check("flush_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("flush_no_inc", cnt(0), 32'd0);
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd0}, 6'h0, 1'b0);
    check("run_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("run_l0_1", cnt(0), 32'd1);

    drive(1'b0, 4'h0, 12'h0, 6'h20, 1'b0);
    tick();
    check("grant_empty_err", {31'd0, error_o}, 32'd1);
    check("grant_empty_l5", cnt(5), 32'd0);
    tick();
    tick();
    check("err_sticky", {31'd0, error_o}, 32'd1);

    reset = 1'b1;
    #1;
    check("rst2_error", {31'd0, error_o}, 32'd0);
    check("rst2_count", {8'd0, laneCount_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    laneActive_i = 6'h1F;
    drive(1'b1, 4'h1, {3'd0, 3'd0, 3'd0, 3'd5}, 6'h0, 1'b0);
    check("inactive_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("inactive_err", {31'd0, error_o}, 32'd1);
    check("inactive_l5", cnt(5), 32'd0);

    laneActive_i = 6'h3F;
    drive(1'b1, 4'h2, {3'd0, 3'd0, 3'd6, 3'd0}, 6'h0, 1'b0);
    check("range_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("range_l0", cnt(0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
